axis_div_core: RTL and testbench

Iterative radix-2 restoring divider that answers the dividend/divisor/dout AXI-stream handshake used by the execute-stage divide wrapper. It sits behind that wrapper and is instantiated twice, once signed and once unsigned. It accepts one operand pair, computes the quotient and remainder over W cycles, and returns them on a single-cycle result strobe. The block needs no vendor IP.

---
 rtl/axis_div_core.sv | 208 ++++++++++++++++++++
 tb/tb_axis_div_core.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_div_core.sv
// axis_div_core
// Iterative radix-2 restoring divider behind an AXI-stream style handshake.
// Each operand channel has its own one-deep buffer. Once both buffers hold
// an operand, the pair moves into the engine and the buffers are freed. The
// engine computes over W iteration cycles. The result is returned on a
// single-cycle strobe.
//
// Parameters:
//   W      operand width; quotient and remainder are each W bits
//   SIGNED 1 = two's-complement division truncating toward zero, 0 = unsigned
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   s_axis_dividend_*           dividend channel (tready = buffer empty)
//   s_axis_divisor_*            divisor channel  (tready = buffer empty)
//   m_axis_dout_tvalid          one-cycle result strobe (no back-pressure)
//   m_axis_dout_tdata           {quotient, remainder}, held until next result
module axis_div_core #(
  parameter int W      = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           s_axis_dividend_tvalid,
  output logic           s_axis_dividend_tready,
  input  logic [W-1:0]   s_axis_dividend_tdata,
  input  logic           s_axis_divisor_tvalid,
  output logic           s_axis_divisor_tready,
  input  logic [W-1:0]   s_axis_divisor_tdata,
  output logic           m_axis_dout_tvalid,
  output logic [2*W-1:0] m_axis_dout_tdata
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           dvd_full;
  logic           dvs_full;
  logic [W-1:0]   dvd_buf;
  logic [W-1:0]   dvs_buf;
  logic [W-1:0]   dvd_op;
  logic [W-1:0]   dvs_op;
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   dvs_mag;
  logic           quo_neg;
  logic           rem_neg;
  logic           dvs_zero;
  logic [CW-1:0]  cnt;
  logic           both_full;
  logic           take;
  logic           last_iter;
  logic [2*W-1:0] step;
  logic [W-1:0]   quo_fin;
  logic [W-1:0]   rem_fin;

  // Magnitude of an operand; identity in unsigned mode.
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    if (SIGNED && x[W-1]) begin
      mag = -x;
    end else begin
      mag = x;
    end
  endfunction

  // One restoring step: shift {r, q} left and trial-subtract d.
  // quo holds the not-yet-consumed dividend bits in its upper part and the
  // quotient bits generated so far in its lower part.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r,
                                              input logic [W-1:0] q,
                                              input logic [W-1:0] d);
    logic [W:0] sh;
    logic [W:0] diff;
    sh   = {r, q[W-1]};
    diff = sh - {1'b0, d};
    if (!diff[W]) begin
      div_step = {diff[W-1:0], q[W-2:0], 1'b1};
    end else begin
      div_step = {sh[W-1:0], q[W-2:0], 1'b0};
    end
  endfunction

  assign s_axis_dividend_tready = ~dvd_full;
  assign s_axis_divisor_tready  = ~dvs_full;
  assign both_full = dvd_full & dvs_full;
  // The engine takes a new pair only when it is idle or finishing up.
  assign take      = both_full && ((state == IDLE) || (state == FIX));
  assign last_iter = (cnt == CW'(W - 1));
  assign step      = div_step(rem, quo, dvs_mag);
  // The divide-by-zero quotient stays all ones regardless of operand signs.
  assign quo_fin   = (quo_neg && !dvs_zero) ? -step[W-1:0] : step[W-1:0];
  assign rem_fin   = rem_neg ? -step[2*W-1:W] : step[2*W-1:W];

  // Dividend buffer: fills on handshake, empties when the engine takes it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dvd_full <= 1'b0;
      dvd_buf  <= {W{1'b0}};
    end else if (take) begin
      dvd_full <= 1'b0;
    end else if (s_axis_dividend_tvalid && !dvd_full) begin
      dvd_full <= 1'b1;
      dvd_buf  <= s_axis_dividend_tdata;
    end
  end

  // Divisor buffer: fills on handshake, empties when the engine takes it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dvs_full <= 1'b0;
      dvs_buf  <= {W{1'b0}};
    end else if (take) begin
      dvs_full <= 1'b0;
    end else if (s_axis_divisor_tvalid && !dvs_full) begin
      dvs_full <= 1'b1;
      dvs_buf  <= s_axis_divisor_tdata;
    end
  end

  // Engine state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Engine next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (both_full) state_nxt = LOAD;
        else           state_nxt = IDLE;
      end
      LOAD: state_nxt = ITER;
      ITER: begin
        if (last_iter) state_nxt = FIX;
        else           state_nxt = ITER;
      end
      FIX: begin
        if (both_full) state_nxt = LOAD;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Engine datapath and result registers. The final iteration also applies
  // the sign fixup and registers the result, so the strobe is high while
  // the state is FIX.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dvd_op             <= {W{1'b0}};
      dvs_op             <= {W{1'b0}};
      rem                <= {W{1'b0}};
      quo                <= {W{1'b0}};
      dvs_mag            <= {W{1'b0}};
      quo_neg            <= 1'b0;
      rem_neg            <= 1'b0;
      dvs_zero           <= 1'b0;
      cnt                <= {CW{1'b0}};
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= {(2*W){1'b0}};
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state)
        IDLE, FIX: begin
          if (take) begin
            dvd_op <= dvd_buf;
            dvs_op <= dvs_buf;
          end
        end
        LOAD: begin
          quo      <= mag(dvd_op);
          dvs_mag  <= mag(dvs_op);
          rem      <= {W{1'b0}};
          quo_neg  <= SIGNED & (dvd_op[W-1] ^ dvs_op[W-1]);
          rem_neg  <= SIGNED & dvd_op[W-1];
          dvs_zero <= (dvs_op == {W{1'b0}});
          cnt      <= {CW{1'b0}};
        end
        ITER: begin
          rem <= step[2*W-1:W];
          quo <= step[W-1:0];
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            m_axis_dout_tvalid <= 1'b1;
            m_axis_dout_tdata  <= {quo_fin, rem_fin};
          end
        end
        default: begin
          cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_div_core.sv
// Testbench for axis_div_core: an unsigned and a signed instance share the
// same stimulus. Results are checked against a plain-arithmetic model.
module tb_axis_div_core;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        dvd_valid = 1'b0;
  logic [31:0] dvd_data = 32'd0;
  logic        dvs_valid = 1'b0;
  logic [31:0] dvs_data = 32'd0;

  logic        u_dvd_ready, u_dvs_ready, u_valid;
  logic [63:0] u_data;
  logic        s_dvd_ready, s_dvs_ready, s_valid;
  logic [63:0] s_data;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  axis_div_core #(.W(32), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .resetn(resetn),
    .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(u_dvd_ready),
    .s_axis_dividend_tdata(dvd_data),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(u_dvs_ready),
    .s_axis_divisor_tdata(dvs_data),
    .m_axis_dout_tvalid(u_valid), .m_axis_dout_tdata(u_data)
  );

  axis_div_core #(.W(32), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .resetn(resetn),
    .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(s_dvd_ready),
    .s_axis_dividend_tdata(dvd_data),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(s_dvs_ready),
    .s_axis_divisor_tdata(dvs_data),
    .m_axis_dout_tvalid(s_valid), .m_axis_dout_tdata(s_data)
  );

  // Reference: integer division truncating toward zero, remainder with the
  // dividend's sign; divide by zero gives all-ones quotient, raw dividend.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  // Advance to the next sampling point (falling edge).
  task automatic tick();
    @(negedge clk);
  endtask

  // Wait (bounded) for a strobe on the unsigned instance and capture both.
  task automatic wait_strobe(output int at, output logic [63:0] du,
                             output logic [63:0] ds, output logic s_too);
    at = -1; du = 64'd0; ds = 64'd0; s_too = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (u_valid) begin
        at = edge_cnt; du = u_data; ds = s_data; s_too = s_valid;
        break;
      end
    end
  endtask

  // Present a pair together; returns the acceptance edge number.
  task automatic send_pair(input logic [31:0] a, input logic [31:0] b, output int acc);
    for (int i = 0; i < 60 && !(u_dvd_ready && u_dvs_ready); i++) tick();
    dvd_valid = 1'b1; dvd_data = a;
    dvs_valid = 1'b1; dvs_data = b;
    tick();
    acc = edge_cnt;
    dvd_valid = 1'b0; dvs_valid = 1'b0;
  endtask

  // Run one operation; lat is -1 when no strobe appears.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output logic [63:0] du, output logic [63:0] ds,
                        output logic s_too);
    int acc, at;
    send_pair(a, b, acc);
    wait_strobe(at, du, ds, s_too);
    lat = (at < 0) ? -1 : at - acc;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    checks++;
    if ({u_dvd_ready, u_dvs_ready, s_dvd_ready, s_dvs_ready} !== 4'b1111) begin
      errors++;
      $display("FAIL reset_tready got %b want 1111",
               {u_dvd_ready, u_dvs_ready, s_dvd_ready, s_dvs_ready});
    end
    checks++;
    if ({u_valid, s_valid} !== 2'b00 || u_data !== 64'd0 || s_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_dout got v=%b%b u=%h s=%h want 0", u_valid, s_valid, u_data, s_data);
    end
  endtask

  task automatic test_basic();
    int acc, at;
    logic [63:0] du, ds;
    logic s_too;
    dvd_valid = 1'b1; dvd_data = 32'd100;
    dvs_valid = 1'b1; dvs_data = 32'd7;
    tick();
    acc = edge_cnt;
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    checks++;
    if ({u_dvd_ready, u_dvs_ready} !== 2'b00) begin
      errors++;
      $display("FAIL basic_ready_low got %b want 00", {u_dvd_ready, u_dvs_ready});
    end
    tick();
    checks++;
    if ({u_dvd_ready, u_dvs_ready} !== 2'b11) begin
      errors++;
      $display("FAIL basic_ready_back got %b want 11", {u_dvd_ready, u_dvs_ready});
    end
    wait_strobe(at, du, ds, s_too);
    checks++;
    if (at - acc !== 34) begin
      errors++;
      $display("FAIL basic_latency got %0d want 34", at - acc);
    end
    checks++;
    if (du !== {32'h0000_000E, 32'h0000_0002} || ds !== {32'h0000_000E, 32'h0000_0002}
        || s_too !== 1'b1) begin
      errors++;
      $display("FAIL basic_data got u=%h s=%h sv=%b want 0000000e00000002", du, ds, s_too);
    end
    tick();
    checks++;
    if ({u_valid, s_valid} !== 2'b00) begin
      errors++;
      $display("FAIL basic_strobe_len got %b%b want 00", u_valid, s_valid);
    end
  endtask

  task automatic test_corner_cases();
    logic [31:0] av [5] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FF00};
    logic [31:0] bv [5] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0};
    int lat;
    logic [63:0] du, ds, eu, es;
    logic s_too;
    for (int i = 0; i < 5; i++) begin
      run_op(av[i], bv[i], lat, du, ds, s_too);
      eu = model(av[i], bv[i], 1'b0);
      es = model(av[i], bv[i], 1'b1);
      checks++;
      if (lat !== 34 || du !== eu || ds !== es || s_too !== 1'b1) begin
        errors++;
        $display("FAIL corner_%0d %h/%h got lat=%0d u=%h s=%h want lat=34 u=%h s=%h",
                 i, av[i], bv[i], lat, du, ds, eu, es);
      end
    end
  endtask

  task automatic test_independent();
    int e0, at;
    logic [63:0] du, ds;
    logic s_too;
    dvd_valid = 1'b1; dvd_data = 32'd1000;
    tick();
    e0 = edge_cnt;
    dvd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({u_dvd_ready, u_dvs_ready} !== 2'b01) begin
        errors++;
        $display("FAIL indep_wait_%0d got %b want 01", i, {u_dvd_ready, u_dvs_ready});
      end
      tick();
    end
    dvs_valid = 1'b1; dvs_data = 32'd33;
    tick();
    dvs_valid = 1'b0;
    checks++;
    if ({u_dvd_ready, u_dvs_ready} !== 2'b00 || edge_cnt !== e0 + 5) begin
      errors++;
      $display("FAIL indep_pair got %b at +%0d want 00 at +5", {u_dvd_ready, u_dvs_ready},
               edge_cnt - e0);
    end
    tick();
    checks++;
    if ({u_dvd_ready, u_dvs_ready} !== 2'b11) begin
      errors++;
      $display("FAIL indep_load got %b want 11", {u_dvd_ready, u_dvs_ready});
    end
    wait_strobe(at, du, ds, s_too);
    checks++;
    if (at - e0 !== 39 || du !== model(32'd1000, 32'd33, 1'b0)
        || ds !== model(32'd1000, 32'd33, 1'b1)) begin
      errors++;
      $display("FAIL indep_result got +%0d u=%h s=%h want +39 u=%h", at - e0, du, ds,
               model(32'd1000, 32'd33, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    int e1, e2, at1, at2;
    logic [63:0] du, ds;
    logic s_too;
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom_range(1, 5000);
    a2 = $urandom; b2 = $urandom;
    send_pair(a1, b1, e1);
    repeat (10) tick();
    send_pair(a2, b2, e2);
    wait_strobe(at1, du, ds, s_too);
    checks++;
    if (at1 - e1 !== 34 || du !== model(a1, b1, 1'b0) || ds !== model(a1, b1, 1'b1)) begin
      errors++;
      $display("FAIL b2b_first got +%0d u=%h s=%h want +34 u=%h s=%h", at1 - e1, du, ds,
               model(a1, b1, 1'b0), model(a1, b1, 1'b1));
    end
    tick();
    checks++;
    if (u_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_strobe_len got %b want 0", u_valid);
    end
    wait_strobe(at2, du, ds, s_too);
    checks++;
    if (at2 - at1 !== 34 || du !== model(a2, b2, 1'b0) || ds !== model(a2, b2, 1'b1)) begin
      errors++;
      $display("FAIL b2b_second got +%0d u=%h s=%h want +34 u=%h s=%h", at2 - at1, du, ds,
               model(a2, b2, 1'b0), model(a2, b2, 1'b1));
    end
    tick();
    checks++;
    if (u_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_strobe2_len got %b want 0", u_valid);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [63:0] du, ds;
    logic s_too;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom_range(1, 15);
        1: b = 32'd0 - 32'($urandom_range(1, 15));
        2: b = 32'd0;
        default: b = $urandom;
      endcase
      if (i == 3) a = 32'h8000_0000;
      run_op(a, b, lat, du, ds, s_too);
      checks++;
      if (lat !== 34 || du !== model(a, b, 1'b0) || ds !== model(a, b, 1'b1)
          || s_too !== 1'b1) begin
        errors++;
        $display("FAIL random_%0d %h/%h got lat=%0d u=%h s=%h want u=%h s=%h", i, a, b, lat,
                 du, ds, model(a, b, 1'b0), model(a, b, 1'b1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, seen, lat;
    logic [63:0] du, ds;
    logic s_too;
    send_pair(32'hDEAD_BEEF, 32'd13, acc);
    while (edge_cnt < acc + 12) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++;
    if ({u_dvd_ready, u_dvs_ready, s_dvd_ready, s_dvs_ready} !== 4'b1111) begin
      errors++;
      $display("FAIL midreset_ready got %b want 1111",
               {u_dvd_ready, u_dvs_ready, s_dvd_ready, s_dvs_ready});
    end
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      if (u_valid || s_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_no_strobe got %0d strobes want 0", seen);
    end
    run_op(32'd9, 32'd3, lat, du, ds, s_too);
    checks++;
    if (lat !== 34 || du !== {32'd3, 32'd0} || ds !== {32'd3, 32'd0}) begin
      errors++;
      $display("FAIL midreset_fresh got lat=%0d u=%h s=%h want 34 0000000300000000",
               lat, du, ds);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_corner_cases();
    test_independent();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
